// File: rtl/dff_share_pkg.sv
// Shared types and helpers for the shared-register arbiter.
package dff_share_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} share_state_t;

  // Width of the generic one-hot vector; callers keep only the low N_REQ bits.
  localparam int ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [4:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request after ptr, wrapping.
module rr_pick
  import dff_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Walk farthest-first so the nearest set request after ptr is the last to overwrite idx.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/dff_share_ctrl.sv
// Round-robin arbiter that owns one shared WIDTH-bit register (q/qb).
// One write per grant, optional idle gap (HOLD) after each write.
module dff_share_ctrl
  import dff_share_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qb,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] last_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

  share_state_t          state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         sel;
  logic [HW-1:0]         hold_cnt;
  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic [ONEHOT_W-1:0]   pick_oh;
  logic [WIDTH-1:0]      sel_din;
  logic                  onehot_unused;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_oh = onehot(5'(pick_idx));

  // Upper bits of the generic one-hot are never set for this N_REQ.
  assign onehot_unused = ^pick_oh[ONEHOT_W-1:N_REQ];

  // gnt is only high in WRITE; gating with rst means a reset in that cycle issues no ack.
  assign ack  = gnt & {N_REQ{rst}};
  assign busy = (state != IDLE);

  // Select the granted requester's slice of the packed data bus.
  always_comb begin
    sel_din = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == IW'(i)) sel_din = din[i*WIDTH +: WIDTH];
    end
  end

  // Arbitration FSM, hold counter, RR pointer and the shared register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      q        <= '0;
      qb       <= '1;
      last_id  <= '0;
      ptr      <= IW'(N_REQ - 1);
      sel      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= WRITE;
            sel   <= pick_idx;
            gnt   <= pick_oh[N_REQ-1:0];
          end
        end
        WRITE: begin
          q       <= sel_din;
          qb      <= ~sel_din;
          last_id <= sel;
          ptr     <= sel;
          gnt     <= '0;
          if (HOLD_CYCLES > 0) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
